// File: rtl/stream_loader.sv
// stream_loader: gathers an out-of-order stream of words into a 2**AW-deep
// buffer, tracks which addresses have arrived, and serves reads once every
// word of the requested load has been written.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   load_start/load_len begin a load of load_len distinct words (1..2**AW)
//   clear               abort back to IDLE (err and storage untouched)
//   stream_v/a/d        incoming word strobe, address and data
//   rd_req/rd_addr      read request; answered one cycle later
//   rd_valid/rd_data    read response
//   ready               a complete load is held
//   load_done           one-cycle pulse on load completion
//   word_cnt            distinct addresses written in the current load
//   err                 sticky error (bad load_len or out-of-range write)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no load in progress, buffer not readable
// S_LOAD  | collecting stream words until word_cnt == len
// S_READY | load complete, reads served, stream ignored
module stream_loader #(
    parameter int DW = 128,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          clear,
    input  logic          stream_v,
    input  logic [AW-1:0] stream_a,
    input  logic [DW-1:0] stream_d,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          ready,
    output logic          load_done,
    output logic [AW:0]   word_cnt,
    output logic          err
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

    state_t              state, state_nxt;
    logic [DW-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]    mask;
    logic [AW:0]         len_q;

    logic                len_ok;
    logic                accept;
    logic                in_range;
    logic                wr_en;
    logic                new_word;
    logic [AW:0]         cnt_nxt;
    logic                done_hit;
    logic                err_set;
    logic                rd_hit;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = (state == S_READY);
        len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
        in_range  = ({1'b0, stream_a} < len_q);
        // load_start only counts outside LOAD; clear beats everything
        accept    = !clear && load_start && len_ok && (state != S_LOAD);
        wr_en     = !clear && (state == S_LOAD) && stream_v && in_range;
        new_word  = wr_en && !mask[stream_a];
        cnt_nxt   = word_cnt + (AW+1)'(new_word);
        done_hit  = new_word && (cnt_nxt == len_q);
        err_set   = !clear &&
                    ((load_start && !len_ok && (state != S_LOAD)) ||
                     ((state == S_LOAD) && stream_v && !in_range));
        // reads sample the pre-transition state, so a read on the exit cycle is served
        rd_hit    = rd_req && (state == S_READY);

        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept)   state_nxt = S_LOAD;
                S_LOAD:  if (done_hit) state_nxt = S_READY;
                S_READY: if (accept)   state_nxt = S_LOAD;
                default:               state_nxt = S_IDLE;
            endcase
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem[stream_a] <= stream_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask      <= '0;
            word_cnt  <= '0;
            len_q     <= '0;
            err       <= 1'b0;
            load_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            load_done <= done_hit;
            rd_valid  <= rd_hit;
            if (rd_hit) rd_data <= mem[rd_addr];

            if (clear) begin
                mask     <= '0;
                word_cnt <= '0;
            end else if (accept) begin
                mask     <= '0;
                word_cnt <= '0;
                len_q    <= load_len;
                err      <= 1'b0;
            end else begin
                if (new_word) begin
                    mask[stream_a] <= 1'b1;
                    word_cnt       <= cnt_nxt;
                end
                if (err_set) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_loader.sv
module tb_stream_loader;
    localparam int DW = 128;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          clear;
    logic          stream_v;
    logic [AW-1:0] stream_a;
    logic [DW-1:0] stream_d;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic          load_done;
    logic [AW:0]   word_cnt;
    logic          err;

    stream_loader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .clear(clear), .stream_v(stream_v), .stream_a(stream_a), .stream_d(stream_d),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .ready(ready), .load_done(load_done), .word_cnt(word_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            m_have [DEPTH];
    bit            m_loading = 0;
    bit            m_ready = 0;
    bit            m_err = 0;
    int            m_len = 0;
    bit            live = 0;
    bit            e_rd_valid = 0;
    logic [DW-1:0] e_rd_data = '0;
    bit            e_rd_known = 1;
    bit            e_load_done = 0;

    function automatic int have_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_have[i]);
        return c;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            live = 1;
            m_loading = 0; m_ready = 0; m_err = 0; m_len = 0;
            for (int i = 0; i < DEPTH; i++) m_have[i] = 0;
            e_rd_valid = 0; e_rd_data = '0; e_rd_known = 1; e_load_done = 0;
        end else begin
            e_load_done = 0;
            if (rd_req && m_ready) begin
                e_rd_valid = 1;
                e_rd_data  = m_mem[rd_addr];
                e_rd_known = m_known[rd_addr];
            end else begin
                e_rd_valid = 0;
            end
            if (clear) begin
                m_loading = 0; m_ready = 0;
                for (int i = 0; i < DEPTH; i++) m_have[i] = 0;
            end else if (m_loading) begin
                if (stream_v) begin
                    if (int'(stream_a) < m_len) begin
                        bit fresh = !m_have[stream_a];
                        m_mem[stream_a]   = stream_d;
                        m_known[stream_a] = 1;
                        m_have[stream_a]  = 1;
                        if (fresh && have_count() == m_len) begin
                            m_loading = 0; m_ready = 1; e_load_done = 1;
                        end
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (load_start) begin
                if (int'(load_len) >= 1 && int'(load_len) <= DEPTH) begin
                    m_loading = 1; m_ready = 0; m_err = 0; m_len = int'(load_len);
                    for (int i = 0; i < DEPTH; i++) m_have[i] = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("rd_valid", DW'(rd_valid), DW'(e_rd_valid));
            if (e_rd_known) chk("rd_data", rd_data, e_rd_data);
            chk("ready", DW'(ready), DW'(m_ready));
            chk("load_done", DW'(load_done), DW'(e_load_done));
            chk("word_cnt", DW'(word_cnt), DW'(have_count()));
            chk("err", DW'(err), DW'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        load_start = 0; stream_v = 0; rd_req = 0; clear = 0;
    endtask

    task automatic do_load(input int n);
        load_start = 1; load_len = 9'(n); step();
    endtask

    task automatic do_wr(input int a, input logic [DW-1:0] d);
        stream_v = 1; stream_a = 8'(a); stream_d = d; step();
    endtask

    task automatic do_rd(input int a);
        rd_req = 1; rd_addr = 8'(a); step();
    endtask

    localparam logic [DW-1:0] DA = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    localparam logic [DW-1:0] DB = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    localparam logic [DW-1:0] DC = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    localparam logic [DW-1:0] DD = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;
    localparam logic [DW-1:0] DE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [DW-1:0] DF = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [DW-1:0] DG = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    initial begin
        rst = 0; load_start = 0; load_len = '0; clear = 0; stream_v = 0;
        stream_a = '0; stream_d = '0; rd_req = 0; rd_addr = '0;
        step(); step();
        rst = 1;
        chk("rst_ready", DW'(ready), '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_word_cnt", DW'(word_cnt), '0);

        // out-of-order load of 4
        do_load(4);
        do_wr(3, DA); do_wr(0, DB); do_wr(2, DC);
        chk("pre_done_cnt", DW'(word_cnt), 128'd3);
        do_wr(1, DD);
        chk("done_pulse", DW'(load_done), 128'd1);
        chk("done_ready", DW'(ready), 128'd1);
        chk("done_cnt", DW'(word_cnt), 128'd4);
        do_rd(0); chk("rd0_B", rd_data, DB);
        chk("done_once", DW'(load_done), 128'd0);
        do_rd(1); chk("rd1_D", rd_data, DD);
        do_rd(2); chk("rd2_C", rd_data, DC);
        do_rd(3); chk("rd3_A", rd_data, DA);
        step();
        chk("rd_idle_valid", DW'(rd_valid), 128'd0);

        // rewrites and an out-of-range write
        do_load(2);
        do_wr(0, DE); chk("rw_cnt1", DW'(word_cnt), 128'd1);
        do_wr(0, DF); chk("rw_cnt1b", DW'(word_cnt), 128'd1);
        chk("rw_no_err", DW'(err), 128'd0);
        do_wr(5, DG); chk("oor_err", DW'(err), 128'd1);
        chk("oor_no_done", DW'(load_done), 128'd0);
        do_wr(1, DG); chk("rw_cnt2", DW'(word_cnt), 128'd2);
        chk("rw_done", DW'(load_done), 128'd1);
        do_rd(0); chk("rw_mem0", rd_data, DF);

        // READY: bad load_len keeps READY and sets err
        do_load(0);
        chk("ready_badlen_ready", DW'(ready), 128'd1);
        chk("ready_badlen_err", DW'(err), 128'd1);

        // IDLE: bad lengths, then a good one
        clear = 1; step();
        do_load(0);   chk("len0_err", DW'(err), 128'd1);
        do_load(257); chk("len257_err", DW'(err), 128'd1);
        chk("len257_ready", DW'(ready), 128'd0);
        do_rd(0);     chk("idle_rd_valid", DW'(rd_valid), 128'd0);
        do_load(1);   chk("len1_err_clr", DW'(err), 128'd0);
        do_wr(0, DA); chk("len1_done", DW'(load_done), 128'd1);

        // read on the cycle READY is left is still served
        rd_req = 1; rd_addr = 8'd0; clear = 1; step();
        chk("exit_rd_valid", DW'(rd_valid), 128'd1);
        chk("exit_rd_data", rd_data, DA);
        chk("exit_ready", DW'(ready), 128'd0);

        // clear beats the completing write
        do_load(2);
        do_wr(0, DB);
        stream_v = 1; stream_a = 8'd1; stream_d = DC; clear = 1; step();
        chk("clr_no_done", DW'(load_done), 128'd0);
        chk("clr_ready", DW'(ready), 128'd0);
        chk("clr_cnt", DW'(word_cnt), 128'd0);
        do_rd(1);
        chk("clr_rd_valid", DW'(rd_valid), 128'd0);

        // full depth, descending
        do_load(256);
        for (int a = 255; a >= 0; a--) do_wr(a, {16{8'(a)}});
        chk("full_cnt", DW'(word_cnt), 128'd256);
        chk("full_done", DW'(load_done), 128'd1);
        chk("full_ready", DW'(ready), 128'd1);
        do_wr(7, DE);
        chk("ready_sv_err", DW'(err), 128'd0);
        do_rd(7);   chk("full_rd7", rd_data, {16{8'h07}});
        do_rd(255); chk("full_rd255", rd_data, {16{8'hFF}});
        do_rd(128); chk("full_rd128", rd_data, {16{8'h80}});

        // reset mid-load, then a normal load of 8
        do_load(8);
        do_wr(9, DA);   // out of range to make err sticky
        do_wr(0, DA); do_wr(1, DB); do_wr(2, DC);
        rst = 0; step();
        chk("mid_rst_err", DW'(err), '0);
        chk("mid_rst_cnt", DW'(word_cnt), '0);
        chk("mid_rst_rd_data", rd_data, '0);
        chk("mid_rst_ready", DW'(ready), '0);
        rst = 1;
        stream_v = 1; stream_a = 8'd3; stream_d = DD; step();
        chk("post_rst_idle_cnt", DW'(word_cnt), '0);
        do_load(8);
        for (int a = 0; a < 8; a++) do_wr(a, {8{16'(a + 16'h5A00)}});
        chk("post_rst_done", DW'(load_done), 128'd1);
        chk("post_rst_cnt", DW'(word_cnt), 128'd8);
        do_rd(6); chk("post_rst_rd6", rd_data, {8{16'h5A06}});
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
